// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared types and tables for the seven-segment scan driver
// Contents:
//   scan_state_t : scan FSM states (DRIVE, BLANK)
//   PAGE_*       : swOp page encodings
//   SEG_TABLE    : 16-entry active-low {g,f,e,d,c,b,a} code table, index = hex nibble
package seg_scan_driver_pkg;

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_t;

  localparam logic [1:0] PAGE_PC  = 2'b00;  // curPC   : nextPC
  localparam logic [1:0] PAGE_RS  = 2'b01;  // rs      : ReadData1
  localparam logic [1:0] PAGE_RT  = 2'b10;  // rt      : ReadData2
  localparam logic [1:0] PAGE_ALU = 2'b11;  // alu_out : WriteData

  // Packed so that SEG_TABLE[n] is the code for nibble n (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// rtl/seg_scan_driver_hex_to_seg.sv - hex nibble to active-low seven-segment code
// Ports:
//   nibble in  4  hex digit value
//   seg    out 7  segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit multiplexed seven-segment driver for CPU debug bytes
// Configuration macro: SEG_GHOST_BLANK_EN (inserts an all-off BLANK phase between digits)
// Ports:
//   CLK        in  1  system clock, rising edge
//   Reset      in  1  synchronous active-high reset
//   load       in  1  strobe: snapshot the eight value inputs into shadows
//   swOp       in  2  page select, adopted at the next digit boundary
//   curPC, nextPC, ReadData1, ReadData2, alu_out, WriteData  in 8  debug bytes
//   rs, rt     in  5  register numbers (zero-extended to 8 bits)
//   an         out 4  digit enables, active-low, an[3] leftmost (registered)
//   dispcode   out 7  segments {g,f,e,d,c,b,a}, active-low (registered)
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       load,
  input  logic [1:0] swOp,
  input  logic [7:0] curPC,
  input  logic [7:0] nextPC,
  input  logic [7:0] ReadData1,
  input  logic [7:0] ReadData2,
  input  logic [7:0] alu_out,
  input  logic [7:0] WriteData,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic [3:0] an,
  output logic [6:0] dispcode
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
`ifdef SEG_GHOST_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

  // Shadow copies of the debug inputs; only these are ever displayed.
  logic [7:0] cur_pc_q, next_pc_q, rd1_q, rd2_q, alu_q, wd_q, rs_q, rt_q;

  logic [1:0]       page_q;
  scan_state_t      state_q, state_nxt;
  logic [1:0]       digit_q, digit_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             page_update;

  logic [7:0] left_byte, right_byte;
  logic [3:0] nibble;
  logic [6:0] seg_code;
  logic [3:0] an_nxt;
  logic [6:0] dispcode_nxt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cur_pc_q  <= '0;
      next_pc_q <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      alu_q     <= '0;
      wd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
    end else if (load) begin
      cur_pc_q  <= curPC;
      next_pc_q <= nextPC;
      rd1_q     <= ReadData1;
      rd2_q     <= ReadData2;
      alu_q     <= alu_out;
      wd_q      <= WriteData;
      rs_q      <= {3'b000, rs};
      rt_q      <= {3'b000, rt};
    end
  end

  // FSM state register plus the page latch, which only moves on a digit boundary.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_DRIVE;
      digit_q <= 2'd0;
      cnt_q   <= '0;
      page_q  <= PAGE_PC;
    end else begin
      state_q <= state_nxt;
      digit_q <= digit_nxt;
      cnt_q   <= cnt_nxt;
      if (page_update) begin
        page_q <= swOp;
      end
    end
  end

  always_comb begin
    state_nxt   = state_q;
    digit_nxt   = digit_q;
    cnt_nxt     = cnt_q + CNT_W'(1);
    page_update = 1'b0;
    case (state_q)
      ST_DRIVE: begin
        if (cnt_q == DIGIT_LAST) begin
          cnt_nxt   = '0;
          digit_nxt = digit_q + 2'd1;
`ifdef SEG_GHOST_BLANK_EN
          state_nxt = ST_BLANK;
`else
          page_update = 1'b1;
`endif
        end
      end
`ifdef SEG_GHOST_BLANK_EN
      ST_BLANK: begin
        // The next digit starts when BLANK ends, so the page is adopted here.
        if (cnt_q == BLANK_LAST) begin
          cnt_nxt     = '0;
          state_nxt   = ST_DRIVE;
          page_update = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = ST_DRIVE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output data path: recomputed every cycle from shadows so a load shows up
  // one cycle after the shadows update, regardless of the scan phase.
  always_comb begin
    left_byte  = cur_pc_q;
    right_byte = next_pc_q;
    case (page_q)
      PAGE_RS: begin
        left_byte  = rs_q;
        right_byte = rd1_q;
      end
      PAGE_RT: begin
        left_byte  = rt_q;
        right_byte = rd2_q;
      end
      PAGE_ALU: begin
        left_byte  = alu_q;
        right_byte = wd_q;
      end
      default: begin
        left_byte  = cur_pc_q;
        right_byte = next_pc_q;
      end
    endcase
  end

  always_comb begin
    nibble = right_byte[3:0];
    case (digit_q)
      2'd0: nibble = right_byte[3:0];
      2'd1: nibble = right_byte[7:4];
      2'd2: nibble = left_byte[3:0];
      2'd3: nibble = left_byte[7:4];
      default: nibble = right_byte[3:0];
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (seg_code)
  );

  always_comb begin
    an_nxt          = 4'b1111;
    an_nxt[digit_q] = 1'b0;
    dispcode_nxt    = seg_code;
    if (state_q == ST_BLANK) begin
      an_nxt       = 4'b1111;
      dispcode_nxt = 7'h7F;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      an       <= 4'b1111;
      dispcode <= 7'h7F;
    end else begin
      an       <= an_nxt;
      dispcode <= dispcode_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

`ifdef SEG_GHOST_BLANK_EN
  localparam int PERIOD = 24;
`else
  localparam int PERIOD = 16;
`endif

  // Expected codes per page, packed {digit3, digit2, digit1, digit0}, for
  // curPC=1F nextPC=23 rs=1A ReadData1=C4 rt=05 ReadData2=9E alu_out=B6 WriteData=5C.
  localparam logic [27:0] CODES_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] CODES_P00  = {7'h79, 7'h0E, 7'h24, 7'h30};
  localparam logic [27:0] CODES_P01  = {7'h79, 7'h08, 7'h46, 7'h19};
  localparam logic [27:0] CODES_P10  = {7'h40, 7'h12, 7'h10, 7'h06};
  localparam logic [27:0] CODES_P11  = {7'h03, 7'h02, 7'h12, 7'h46};

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       load = 1'b0;
  logic [1:0] swOp = 2'b00;
  logic [7:0] curPC = '0, nextPC = '0, ReadData1 = '0, ReadData2 = '0;
  logic [7:0] alu_out = '0, WriteData = '0;
  logic [4:0] rs = '0, rt = '0;
  logic [3:0] an;
  logic [6:0] dispcode;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  always #5 CLK = ~CLK;

  seg_scan_driver #(
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .load      (load),
    .swOp      (swOp),
    .curPC     (curPC),
    .nextPC    (nextPC),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .alu_out   (alu_out),
    .WriteData (WriteData),
    .rs        (rs),
    .rt        (rt),
    .an        (an),
    .dispcode  (dispcode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at sample %0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    k++;
  endtask

  // Digit shown at sample k after reset release, or -1 during BLANK.
  function automatic int exp_digit(input int s);
`ifdef SEG_GHOST_BLANK_EN
    int pos;
    pos = s % 24;
    if ((pos % 6) >= 4) return -1;
    return pos / 6;
`else
    return (s % 16) / 4;
`endif
  endfunction

  task automatic scan_check(input string tag, input logic [27:0] codes, input int n);
    int d;
    logic [3:0] ea;
    for (int i = 0; i < n; i++) begin
      d = exp_digit(k);
      if (d < 0) begin
        check({tag, "_an_blank"}, 32'(an), 32'hF);
        check({tag, "_seg_blank"}, 32'(dispcode), 32'h7F);
      end else begin
        ea = 4'b1111;
        ea[d] = 1'b0;
        check({tag, "_an"}, 32'(an), 32'(ea));
        check({tag, "_seg"}, 32'(dispcode), 32'(codes[d*7 +: 7]));
      end
      step();
    end
  endtask

  task automatic set_values();
    curPC = 8'h1F; nextPC = 8'h23; rs = 5'h1A; ReadData1 = 8'hC4;
    rt = 5'h05; ReadData2 = 8'h9E; alu_out = 8'hB6; WriteData = 8'h5C;
  endtask

  // Leaves the bench at sample 0: first cycle after release.
  task automatic do_reset(input logic [1:0] sw);
    swOp = sw;
    load = 1'b0;
    Reset = 1'b1;
    repeat (3) step();
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(dispcode), 32'h7F);
    Reset = 1'b0;
    step();
    k = 0;
  endtask

  // Load at sample 0; sample 1 still old, sample 2 new; page from swOp after first boundary.
  task automatic page_test(input string tag, input logic [1:0] sw, input logic [27:0] codes);
    do_reset(sw);
    set_values();
    load = 1'b1;
    scan_check({tag, "_pre"}, CODES_ZERO, 1);
    load = 1'b0;
    scan_check({tag, "_lat1"}, CODES_ZERO, 1);
    scan_check({tag, "_d0"}, CODES_P00, 2);
    scan_check(tag, codes, PERIOD);
  endtask

  initial begin
    // Idle scan after reset.
    do_reset(2'b00);
    scan_check("idle", CODES_ZERO, 2 * PERIOD);

    // Each page, with swOp already set during reset (page starts at 00).
    page_test("p00", 2'b00, CODES_P00);
    page_test("p01", 2'b01, CODES_P01);
    page_test("p10", 2'b10, CODES_P10);
    page_test("p11", 2'b11, CODES_P11);

    // swOp change in the middle of digit 0.
    do_reset(2'b00);
    set_values();
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    swOp = 2'b01;
    scan_check("mid_old", CODES_P00, 2);
    scan_check("mid_new", CODES_P01, PERIOD);

    // Reset and load together: reset wins, shadows cleared.
    Reset = 1'b1;
    load = 1'b1;
    curPC = 8'hFF; nextPC = 8'hFF; rs = 5'h1F; ReadData1 = 8'hFF;
    step();
    load = 1'b0;
    check("rl_an", 32'(an), 32'hF);
    check("rl_seg", 32'(dispcode), 32'h7F);
    swOp = 2'b00;
    Reset = 1'b0;
    step();
    k = 0;
    scan_check("rl_scan", CODES_ZERO, PERIOD);

    // Reset in the middle of digit 2 aborts the phase.
    do_reset(2'b00);
    set_values();
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 64 && exp_digit(k) != 2; i++) step();
    check("mid2_reached", 32'(an), 32'hB);
    step();
    Reset = 1'b1;
    step();
    check("abort_an", 32'(an), 32'hF);
    check("abort_seg", 32'(dispcode), 32'h7F);
    Reset = 1'b0;
    step();
    k = 0;
    check("restart_an", 32'(an), 32'hE);
    check("restart_seg", 32'(dispcode), 32'h40);
    scan_check("restart_scan", CODES_ZERO, PERIOD);

`ifdef SEG_GHOST_BLANK_EN
    // Reset during a BLANK phase.
    for (int i = 0; i < 64 && exp_digit(k) != -1; i++) step();
    check("blank_reached", 32'(an), 32'hF);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
    k = 0;
    check("blank_restart_an", 32'(an), 32'hE);
    check("blank_restart_seg", 32'(dispcode), 32'h40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
